// File: rtl/rps_match_ctrl.sv
// First-to-WIN_TARGET stone-paper-scissors match controller with scores, round limit and winner.
// Optional round history shift register enabled by defining RPS_HISTORY_EN.
module rps_match_ctrl #(
  parameter int WIN_TARGET = 3,
  parameter int SCORE_W    = 4,
  parameter int MAX_ROUNDS = 15,
  parameter int RND_W      = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic [1:0]         p1_move,
  input  logic [1:0]         p2_move,
  input  logic               start,
  input  logic               clear,
  output logic [1:0]         round_result,
  output logic               result_valid,
  output logic [SCORE_W-1:0] p1_score,
  output logic [SCORE_W-1:0] p2_score,
  output logic [RND_W-1:0]   round_count,
  output logic               match_over,
  output logic [1:0]         match_winner,
  output logic [7:0]         history
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EVAL = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  localparam logic [SCORE_W-1:0] SCORE_ONE  = SCORE_W'(1);
  localparam logic [SCORE_W-1:0] SCORE_WIN  = SCORE_W'(WIN_TARGET);
  localparam logic [RND_W-1:0]   RND_ONE    = RND_W'(1);
  localparam logic [RND_W-1:0]   RND_LIMIT  = RND_W'(MAX_ROUNDS);

  // Encoding: 00 stone, 01 paper, 10 scissors; each move beats the one "below" it cyclically.
  function automatic logic [1:0] judge(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] r;
    if ((a == 2'b11) || (b == 2'b11)) begin
      r = 2'b11;
    end else if (a == b) begin
      r = 2'b00;
    end else if (((a == 2'b00) && (b == 2'b10)) ||
                 ((a == 2'b01) && (b == 2'b00)) ||
                 ((a == 2'b10) && (b == 2'b01))) begin
      r = 2'b01;
    end else begin
      r = 2'b10;
    end
    return r;
  endfunction

  state_t             state_r, state_nxt_s;
  logic               start_q_r;
  logic [1:0]         p1_mv_r, p1_mv_nxt_s, p2_mv_r, p2_mv_nxt_s;
  logic [1:0]         round_result_r, round_result_nxt_s;
  logic               result_valid_r, result_valid_nxt_s;
  logic [SCORE_W-1:0] p1_score_r, p1_score_nxt_s, p2_score_r, p2_score_nxt_s;
  logic [SCORE_W-1:0] p1_upd_s, p2_upd_s;
  logic [RND_W-1:0]   round_count_r, round_count_nxt_s, rc_upd_s;
  logic               match_over_r, match_over_nxt_s;
  logic [1:0]         match_winner_r, match_winner_nxt_s;
  logic [1:0]         res_s;
  logic               start_edge_s;
  logic               done_s;

  assign start_edge_s = start & ~start_q_r;
  assign res_s        = judge(p1_mv_r, p2_mv_r);

  // Counter values as they would be after judging the captured round.
  always_comb begin
    p1_upd_s = p1_score_r;
    p2_upd_s = p2_score_r;
    rc_upd_s = round_count_r;
    case (res_s)
      2'b01: begin
        p1_upd_s = p1_score_r + SCORE_ONE;
        rc_upd_s = round_count_r + RND_ONE;
      end
      2'b10: begin
        p2_upd_s = p2_score_r + SCORE_ONE;
        rc_upd_s = round_count_r + RND_ONE;
      end
      2'b00: rc_upd_s = round_count_r + RND_ONE;
      default: rc_upd_s = round_count_r;
    endcase
    done_s = (p1_upd_s == SCORE_WIN) || (p2_upd_s == SCORE_WIN) || (rc_upd_s == RND_LIMIT);
  end

  // Next-state and next registered-output logic.
  always_comb begin
    state_nxt_s        = state_r;
    p1_mv_nxt_s        = p1_mv_r;
    p2_mv_nxt_s        = p2_mv_r;
    round_result_nxt_s = round_result_r;
    result_valid_nxt_s = 1'b0;
    p1_score_nxt_s     = p1_score_r;
    p2_score_nxt_s     = p2_score_r;
    round_count_nxt_s  = round_count_r;
    match_over_nxt_s   = match_over_r;
    match_winner_nxt_s = match_winner_r;
    if (clear) begin
      state_nxt_s        = ST_IDLE;
      round_result_nxt_s = 2'b00;
      p1_score_nxt_s     = {SCORE_W{1'b0}};
      p2_score_nxt_s     = {SCORE_W{1'b0}};
      round_count_nxt_s  = {RND_W{1'b0}};
      match_over_nxt_s   = 1'b0;
      match_winner_nxt_s = 2'b00;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_edge_s) begin
            p1_mv_nxt_s = p1_move;
            p2_mv_nxt_s = p2_move;
            state_nxt_s = ST_EVAL;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_EVAL: begin
          round_result_nxt_s = res_s;
          result_valid_nxt_s = 1'b1;
          p1_score_nxt_s     = p1_upd_s;
          p2_score_nxt_s     = p2_upd_s;
          round_count_nxt_s  = rc_upd_s;
          if (done_s) begin
            state_nxt_s      = ST_DONE;
            match_over_nxt_s = 1'b1;
            // Target score decides first; at the round limit the higher score wins.
            if (p1_upd_s == SCORE_WIN) begin
              match_winner_nxt_s = 2'b01;
            end else if (p2_upd_s == SCORE_WIN) begin
              match_winner_nxt_s = 2'b10;
            end else if (p1_upd_s > p2_upd_s) begin
              match_winner_nxt_s = 2'b01;
            end else if (p2_upd_s > p1_upd_s) begin
              match_winner_nxt_s = 2'b10;
            end else begin
              match_winner_nxt_s = 2'b00;
            end
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_DONE: state_nxt_s = ST_DONE;
        default: state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // State and output registers; ena=0 freezes everything, including the start edge detector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= ST_IDLE;
      start_q_r      <= 1'b0;
      p1_mv_r        <= 2'b00;
      p2_mv_r        <= 2'b00;
      round_result_r <= 2'b00;
      result_valid_r <= 1'b0;
      p1_score_r     <= {SCORE_W{1'b0}};
      p2_score_r     <= {SCORE_W{1'b0}};
      round_count_r  <= {RND_W{1'b0}};
      match_over_r   <= 1'b0;
      match_winner_r <= 2'b00;
    end else if (ena) begin
      state_r        <= state_nxt_s;
      start_q_r      <= start;
      p1_mv_r        <= p1_mv_nxt_s;
      p2_mv_r        <= p2_mv_nxt_s;
      round_result_r <= round_result_nxt_s;
      result_valid_r <= result_valid_nxt_s;
      p1_score_r     <= p1_score_nxt_s;
      p2_score_r     <= p2_score_nxt_s;
      round_count_r  <= round_count_nxt_s;
      match_over_r   <= match_over_nxt_s;
      match_winner_r <= match_winner_nxt_s;
    end
  end

  assign round_result = round_result_r;
  assign result_valid = result_valid_r;
  assign p1_score     = p1_score_r;
  assign p2_score     = p2_score_r;
  assign round_count  = round_count_r;
  assign match_over   = match_over_r;
  assign match_winner = match_winner_r;

`ifdef RPS_HISTORY_EN
  logic [7:0] history_r, history_nxt_s;

  // Newest result enters at [1:0] each time a round is reported, invalid rounds included.
  always_comb begin
    history_nxt_s = history_r;
    if (clear) begin
      history_nxt_s = 8'h00;
    end else if (state_r == ST_EVAL) begin
      history_nxt_s = {history_r[5:0], res_s};
    end else begin
      history_nxt_s = history_r;
    end
  end

  // History register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      history_r <= 8'h00;
    end else if (ena) begin
      history_r <= history_nxt_s;
    end
  end

  assign history = history_r;
`else
  assign history = 8'h00;
`endif

endmodule

// File: tb/tb_rps_match_ctrl.sv
// Directed bench for rps_match_ctrl: default instance plus a MAX_ROUNDS=4 instance on shared inputs.
module tb_rps_match_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [1:0] p1_move = 2'b00;
  logic [1:0] p2_move = 2'b00;
  logic       start = 1'b0;
  logic       clear = 1'b0;

  logic [1:0] rr, rr4;
  logic       rv, rv4;
  logic [3:0] p1s, p2s, p1s4, p2s4;
  logic [4:0] rc, rc4;
  logic       mo, mo4;
  logic [1:0] mw, mw4;
  logic [7:0] hist, hist4;

  int errors = 0;
  int checks = 0;
  int pulses;

  always #5 clk = ~clk;

  rps_match_ctrl dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .p1_move(p1_move), .p2_move(p2_move),
    .start(start), .clear(clear), .round_result(rr), .result_valid(rv),
    .p1_score(p1s), .p2_score(p2s), .round_count(rc), .match_over(mo),
    .match_winner(mw), .history(hist)
  );

  rps_match_ctrl #(.WIN_TARGET(3), .SCORE_W(4), .MAX_ROUNDS(4), .RND_W(5)) dut4 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .p1_move(p1_move), .p2_move(p2_move),
    .start(start), .clear(clear), .round_result(rr4), .result_valid(rv4),
    .p1_score(p1s4), .p2_score(p2s4), .round_count(rc4), .match_over(mo4),
    .match_winner(mw4), .history(hist4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Start edge in the cycle after the current edge; returns one step after the result edge.
  task automatic play(input logic [1:0] m1, input logic [1:0] m2);
    p1_move = m1;
    p2_move = m2;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    chk("rst_rr", rr, 2'b00);
    chk("rst_rv", rv, 1'b0);
    chk("rst_scores", {p1s, p2s}, 8'h00);
    chk("rst_rc", rc, 5'd0);
    chk("rst_over", {mo, mw}, 3'b000);
    chk("rst_hist", hist, 8'h00);
    rst_n = 1'b1;
    tick();

    // P1 wins three straight rounds
    play(2'b00, 2'b10);
    chk("r1_rr", rr, 2'b01);
    chk("r1_rv", rv, 1'b1);
    chk("r1_p1", p1s, 4'd1);
    chk("r1_over", mo, 1'b0);
    play(2'b01, 2'b00);
    chk("r2_rr", rr, 2'b01);
    chk("r2_p1", p1s, 4'd2);
    play(2'b10, 2'b01);
    chk("r3_rr", rr, 2'b01);
    chk("r3_p1", p1s, 4'd3);
    chk("r3_rc", rc, 5'd3);
    chk("r3_over", mo, 1'b1);
    chk("r3_winner", mw, 2'b01);

    // Start in DONE is ignored
    play(2'b00, 2'b01);
    chk("done_rv", rv, 1'b0);
    tick();
    chk("done_rv2", rv, 1'b0);
    chk("done_p2", p2s, 4'd0);
    chk("done_over", mo, 1'b1);

    // clear, then P2 win, tie, invalid
    do_clear();
    #1;
    chk("clr_scores", {p1s, p2s, rc}, 13'd0);
    chk("clr_over", {mo, mw}, 3'b000);
    play(2'b00, 2'b01);
    chk("c1_rr", rr, 2'b10);
    chk("c1_p2", p2s, 4'd1);
    play(2'b01, 2'b01);
    chk("c2_rr", rr, 2'b00);
    chk("c2_rc", rc, 5'd2);
    chk("c2_scores", {p1s, p2s}, 8'h01);
    play(2'b11, 2'b00);
    chk("c3_rr", rr, 2'b11);
    chk("c3_rv", rv, 1'b1);
    chk("c3_scores", {p1s, p2s}, 8'h01);
    chk("c3_rc", rc, 5'd2);
`ifdef RPS_HISTORY_EN
    chk("c3_hist", hist, 8'b00_10_00_11);
`else
    chk("c3_hist", hist, 8'h00);
`endif
    tick();
    chk("c3_rv_low", rv, 1'b0);

    // Round limit on the MAX_ROUNDS=4 instance: P1, P2, tie, tie -> draw
    do_clear();
    play(2'b01, 2'b00);
    play(2'b00, 2'b01);
    play(2'b10, 2'b10);
    chk("lim_not_over", mo4, 1'b0);
    play(2'b00, 2'b00);
    chk("lim_rc", rc4, 5'd4);
    chk("lim_over", mo4, 1'b1);
    chk("lim_winner", mw4, 2'b00);
    chk("lim_dflt_over", mo, 1'b0);
    chk("lim_dflt_rc", rc, 5'd4);
    // P1, P1, P2, tie -> P1 on higher score
    do_clear();
    play(2'b01, 2'b00);
    play(2'b10, 2'b01);
    play(2'b10, 2'b00);
    play(2'b01, 2'b01);
    chk("lim2_over", mo4, 1'b1);
    chk("lim2_winner", mw4, 2'b01);
    chk("lim2_scores", {p1s4, p2s4}, 8'h21);

    // start held high for 10 cycles -> one round
    do_clear();
    p1_move = 2'b00;
    p2_move = 2'b00;
    start = 1'b1;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      pulses += int'(rv);
    end
    chk("hold_pulses", pulses, 1);
    chk("hold_rc", rc, 5'd1);
    // start low only while ena=0, then high again -> no new edge
    start = 1'b0;
    ena = 1'b0;
    tick();
    ena = 1'b1;
    start = 1'b1;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      pulses += int'(rv);
    end
    chk("ena_pulses", pulses, 0);
    chk("ena_rc", rc, 5'd1);
    start = 1'b0;
    tick();

    // Latency: start driven in cycle T -> result_valid exactly at T+2
    start = 1'b1;
    tick();
    chk("lat_t1", rv, 1'b0);
    start = 1'b0;
    tick();
    chk("lat_t2", rv, 1'b1);
    tick();
    chk("lat_t3", rv, 1'b0);

    // clear during EVAL discards the round
    start = 1'b1;
    tick();
    start = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clev_rv", rv, 1'b0);
    chk("clev_cnt", {p1s, p2s, rc, rr}, 15'd0);

    // Asynchronous reset mid-EVAL
    play(2'b01, 2'b00);
    chk("pre_rst_p1", p1s, 4'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_cnt", {p1s, p2s, rc, rr}, 15'd0);
    chk("arst_flags", {rv, mo, mw}, 4'b0000);
    chk("arst_hist", hist, 8'h00);
    tick();
    rst_n = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
